// File: rtl/result_reader.sv
// -----------------------------------------------------------------------------
// result_reader
//
// Reads back one result bank (a, b or c) from its SRAM, starting at address 0,
// and serializes each wide word into OUTPUT_DATA_WIDTH-bit beats. The most
// significant lane of each word goes out first.
//
// Ports
//   clk            single clock, all state changes on its rising edge
//   srst           asynchronous active-high reset
//   start          request a readback, sampled only while idle
//   bank_sel       0 = bank a, 1 = bank b, 2 = bank c, 3 = illegal (no access)
//   num_words      number of words to read, clamped to the SRAM depth
//   sram_raddr_*   registered read addresses, unselected banks held at 0
//   sram_rdata_*   read data, valid one cycle after its address
//   out_valid      out_data holds a valid lane
//   out_ready      downstream accepts the current beat
//   out_data       serialized lane
//   out_last       final beat of the whole transfer
//   busy           transfer in progress (RD, LATCH, SEND)
//   done           single-cycle completion pulse (FIN)
//   dbg_state      current FSM state
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both 1. While out_valid is 1 and out_ready is 0, out_data and out_last
// hold their values, and out_valid stays high until the beat is accepted.
// -----------------------------------------------------------------------------
module result_reader #(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH        = 6
) (
  input  logic                                      clk,
  input  logic                                      srst,
  input  logic                                      start,
  input  logic [1:0]                                bank_sel,
  input  logic [6:0]                                num_words,
  output logic [ADDR_WIDTH-1:0]                     sram_raddr_a,
  output logic [ADDR_WIDTH-1:0]                     sram_raddr_b,
  output logic [ADDR_WIDTH-1:0]                     sram_raddr_c,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_c,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]              out_data,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      done,
  output logic [2:0]                                dbg_state
);

  localparam int W     = OUTPUT_DATA_WIDTH;
  localparam int BUF_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]       state;
  logic [1:0]       bank_q;
  logic [6:0]       nwords_q;
  logic [6:0]       word_idx;
  logic [IDX_W-1:0] idx;
  logic [BUF_W-1:0] shift_buf;

  logic [6:0]            nw_clamped;
  logic [BUF_W-1:0]      rdata_sel;
  logic [BUF_W-1:0]      lane_shifted;
  logic                  idx_last;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Requests longer than the SRAM are trimmed to the full depth.
  always_comb begin
    nw_clamped = num_words;
    if (int'(num_words) > DEPTH) begin
      nw_clamped = 7'(DEPTH);
    end
  end

  always_comb begin
    rdata_sel = '0;
    case (bank_q)
      2'd0:    rdata_sel = sram_rdata_a;
      2'd1:    rdata_sel = sram_rdata_b;
      2'd2:    rdata_sel = sram_rdata_c;
      default: rdata_sel = '0;
    endcase
  end

  assign idx_last  = (idx == IDX_W'(ARRAY_SIZE - 1));
  assign last_word = (word_idx == (nwords_q - 7'd1));
  assign next_addr = ADDR_WIDTH'(word_idx + 7'd1);

  // Lane idx counts from the top of the word: idx 0 is the MSB lane.
  always_comb begin
    lane_shifted = shift_buf >> (W * (ARRAY_SIZE - 1 - int'(idx)));
    out_data     = '0;
    if (state == SEND) begin
      out_data = lane_shifted[W-1:0];
    end
  end

  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && idx_last && last_word;
  assign busy      = (state == RD) || (state == LATCH) || (state == SEND);
  assign done      = (state == FIN);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state        <= IDLE;
      bank_q       <= 2'd0;
      nwords_q     <= 7'd0;
      word_idx     <= 7'd0;
      idx          <= '0;
      shift_buf    <= '0;
      sram_raddr_a <= '0;
      sram_raddr_b <= '0;
      sram_raddr_c <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bank_q       <= bank_sel;
            nwords_q     <= nw_clamped;
            word_idx     <= 7'd0;
            sram_raddr_a <= '0;
            sram_raddr_b <= '0;
            sram_raddr_c <= '0;
            // Empty or illegal requests complete without touching the SRAM.
            if ((num_words == 7'd0) || (bank_sel == 2'd3)) begin
              state <= FIN;
            end else begin
              state <= RD;
            end
          end
        end

        // Address is on the SRAM; data appears after the next edge.
        RD: begin
          state <= LATCH;
        end

        LATCH: begin
          shift_buf <= rdata_sel;
          idx       <= '0;
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            if (idx_last) begin
              if (last_word) begin
                state <= FIN;
              end else begin
                word_idx <= word_idx + 7'd1;
                case (bank_q)
                  2'd0:    sram_raddr_a <= next_addr;
                  2'd1:    sram_raddr_b <= next_addr;
                  2'd2:    sram_raddr_c <= next_addr;
                  default: ;
                endcase
                state <= RD;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// -----------------------------------------------------------------------------
// tb_result_reader
//
// Directed bench for result_reader. Three SRAM models return word contents
// one cycle after the address. Each bank holds a recognisable pattern:
//   bank a: lane l of word w = 16'hA000 | w<<4 | l
//   bank b: lane l of word w = w<<4 | (l+1)    (word 0 = 0x0001..0x0008)
//   bank c: lane l of word w = 16'hC000 | w<<4 | l
// Lane 0 is the least significant lane, so beats run from lane 7 down to 0.
// -----------------------------------------------------------------------------
module tb_result_reader;

  localparam int AS  = 8;
  localparam int W   = 16;
  localparam int AW  = 6;
  localparam int DEP = 64;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  logic              start;
  logic [1:0]        bank_sel;
  logic [6:0]        num_words;
  logic [AW-1:0]     sram_raddr_a, sram_raddr_b, sram_raddr_c;
  logic [AS*W-1:0]   sram_rdata_a, sram_rdata_b, sram_rdata_c;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  result_reader #(
    .ARRAY_SIZE       (AS),
    .OUTPUT_DATA_WIDTH(W),
    .ADDR_WIDTH       (AW)
  ) dut (
    .clk          (clk),
    .srst         (srst),
    .start        (start),
    .bank_sel     (bank_sel),
    .num_words    (num_words),
    .sram_raddr_a (sram_raddr_a),
    .sram_raddr_b (sram_raddr_b),
    .sram_raddr_c (sram_raddr_c),
    .sram_rdata_a (sram_rdata_a),
    .sram_rdata_b (sram_rdata_b),
    .sram_rdata_c (sram_rdata_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------- SRAM models
  logic [AS*W-1:0] mem_a [DEP];
  logic [AS*W-1:0] mem_b [DEP];
  logic [AS*W-1:0] mem_c [DEP];

  function automatic logic [W-1:0] lane_val(input int b, input int w, input int l);
    logic [W-1:0] v;
    case (b)
      0:       v = 16'hA000 | 16'(w << 4) | 16'(l);
      1:       v = 16'(w << 4) | 16'(l + 1);
      default: v = 16'hC000 | 16'(w << 4) | 16'(l);
    endcase
    return v;
  endfunction

  initial begin
    for (int w = 0; w < DEP; w++) begin
      for (int l = 0; l < AS; l++) begin
        mem_a[w][l*W +: W] = lane_val(0, w, l);
        mem_b[w][l*W +: W] = lane_val(1, w, l);
        mem_c[w][l*W +: W] = lane_val(2, w, l);
      end
    end
  end

  always @(posedge clk) begin
    sram_rdata_a <= mem_a[sram_raddr_a];
    sram_rdata_b <= mem_b[sram_raddr_b];
    sram_rdata_c <= mem_c[sram_raddr_c];
  end

  // ---------------------------------------------------------------- scoreboard
  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  // rmode 0: out_ready always 1; rmode 1: out_ready cycles 1,0,0,1.
  // poke: pulse start with bank_sel=0 partway through the transfer.
  task automatic do_transfer(input logic [1:0] bank, input logic [6:0] nw,
                             input int rmode, input bit poke);
    int words;
    int total;
    int beats;
    int cycle;
    int last_cycle;
    bit seen_valid;
    bit got_done;
    logic [AW-1:0] sel_addr;

    words = (int'(nw) > DEP) ? DEP : int'(nw);
    if (bank == 2'd3) words = 0;
    exp_q.delete();
    for (int w = 0; w < words; w++) begin
      for (int l = AS - 1; l >= 0; l--) begin
        exp_q.push_back(lane_val(int'(bank), w, l));
      end
    end
    total      = exp_q.size();
    beats      = 0;
    last_cycle = 0;
    seen_valid = 1'b0;
    got_done   = 1'b0;

    @(negedge clk);
    start     = 1'b1;
    bank_sel  = bank;
    num_words = nw;
    out_ready = 1'b1;
    @(negedge clk);
    // Change the request inputs; the captured values must be used.
    start     = 1'b0;
    bank_sel  = 2'd0;
    num_words = 7'd1;
    cycle     = 1;

    while (cycle < 3000) begin
      out_ready = (rmode == 0) ? 1'b1 : ((cycle % 4 == 0) || (cycle % 4 == 3));
      start     = (poke && (cycle == 10)) ? 1'b1 : 1'b0;

      if (bank != 2'd0) check("raddr_a_unsel", 32'(sram_raddr_a), 32'd0);
      if (bank != 2'd1) check("raddr_b_unsel", 32'(sram_raddr_b), 32'd0);
      if (bank != 2'd2) check("raddr_c_unsel", 32'(sram_raddr_c), 32'd0);

      if (done) begin
        got_done = 1'b1;
        check("beat_count", 32'(beats), 32'(total));
        check("done_timing", 32'(cycle), 32'(last_cycle + 1));
        check("busy_at_done", 32'(busy), 32'd0);
        check("valid_at_done", 32'(out_valid), 32'd0);
        break;
      end

      check("busy_mid", 32'(busy), 32'd1);

      if (out_valid) begin
        if (!seen_valid) begin
          check("first_valid_latency", 32'(cycle), 32'd3);
          seen_valid = 1'b1;
        end
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          case (bank)
            2'd0:    sel_addr = sram_raddr_a;
            2'd1:    sel_addr = sram_raddr_b;
            default: sel_addr = sram_raddr_c;
          endcase
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
          check("raddr_sel", 32'(sel_addr), 32'(beats / AS));
          if (out_ready) begin
            void'(exp_q.pop_front());
            beats++;
            last_cycle = cycle;
          end
        end
      end else begin
        check("last_without_valid", 32'(out_last), 32'd0);
      end

      @(negedge clk);
      cycle++;
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    @(negedge clk);
    check("idle_after_done", 32'(busy | done | out_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_raddr"}, 32'({sram_raddr_a, sram_raddr_b, sram_raddr_c}), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------------------------------------------------------- directed steps
  initial begin
    srst      = 1'b1;
    start     = 1'b0;
    bank_sel  = 2'd0;
    num_words = 7'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    srst = 1'b0;
    @(negedge clk);

    // Bank b, two words, always ready.
    do_transfer(2'd1, 7'd2, 0, 1'b0);
    // Same with ready toggling 1,0,0,1.
    do_transfer(2'd1, 7'd2, 1, 1'b0);
    // Empty and illegal requests.
    do_transfer(2'd0, 7'd0, 0, 1'b0);
    do_transfer(2'd3, 7'd5, 0, 1'b0);
    // Oversized request on bank c: clamped to 64 words, 512 beats.
    do_transfer(2'd2, 7'd100, 0, 1'b0);

    // Reset at beat 5 of word 0.
    @(negedge clk);
    start     = 1'b1;
    bank_sel  = 2'd0;
    num_words = 7'd2;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_beat5", 32'(out_data), 32'(lane_val(0, 0, 3)));
    srst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    check_all_zero("mid_reset_hold");
    srst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
    do_transfer(2'd0, 7'd3, 1, 1'b0);

    // start pulsed while busy with bank_sel=0 is ignored.
    do_transfer(2'd1, 7'd3, 1, 1'b1);
    // A short read on bank c with stalls.
    do_transfer(2'd2, 7'd4, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter ARRAY_SIZE, default 8, number of 16-bit lanes per result SRAM word.
REQ-002 Parameter OUTPUT_DATA_WIDTH, default 16, width of one lane and of out_data.
REQ-003 Parameter ADDR_WIDTH, default 6, result SRAM address width; depth is 2^ADDR_WIDTH = 64 words.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port srst, input, 1, asynchronous active-high reset.
REQ-007 Port start, input, 1, request to read back one result bank; sampled only in IDLE.
REQ-008 Port bank_sel, input, 2, bank select: 0 = bank a, 1 = bank b, 2 = bank c, 3 = illegal.
REQ-009 Port num_words, input, 7, number of SRAM words to read, starting at address 0.
REQ-010 Ports sram_raddr_a, sram_raddr_b, sram_raddr_c, output, ADDR_WIDTH each, registered read addresses.
REQ-011 Ports sram_rdata_a, sram_rdata_b, sram_rdata_c, input, ARRAY_SIZE*OUTPUT_DATA_WIDTH each, read data valid one cycle after the address.
REQ-012 Port out_valid, output, 1, out_data holds a valid lane.
REQ-013 Port out_ready, input, 1, downstream accepts a beat.
REQ-014 Port out_data, output, OUTPUT_DATA_WIDTH, serialized result lane.
REQ-015 Port out_last, output, 1, marks the final beat of the transfer.
REQ-016 Port busy, output, 1, high from the edge that accepts start until the edge that pulses done.
REQ-017 Port done, output, 1, single-cycle completion pulse.

Function
REQ-018 The FSM SHALL use states IDLE, RD, LATCH, SEND and FIN.
REQ-019 In IDLE, start=1 SHALL capture bank_sel and num_words, clear the word counter, drive address 0 on the selected bank, and move to RD.
REQ-020 A captured num_words greater than 64 SHALL be clamped to 64.
REQ-021 Capturing num_words=0 or bank_sel=3 SHALL skip RD and go to FIN: no SRAM access, no beats.
REQ-022 RD SHALL always advance to LATCH.
REQ-023 On the LATCH->SEND edge, the selected bank's rdata SHALL be registered into a shift buffer and the lane index cleared.
REQ-024 In SEND, out_valid=1 and out_data = lane [W*(ARRAY_SIZE-idx)-1 -: W], where W = OUTPUT_DATA_WIDTH; this sends the MSB lane first.
REQ-025 A beat SHALL transfer on an edge where out_valid and out_ready are both 1; idx then increments.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-027 After the beat with idx=ARRAY_SIZE-1, the FSM SHALL go to RD with address+1 if words remain, otherwise to FIN.
REQ-028 out_last SHALL be 1 only during the last lane of the last word.
REQ-029 FIN SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-030 Latency: with start sampled at edge E0, out_valid SHALL first be 1 after edge E2.
REQ-031 Each word SHALL cost 2 overhead cycles plus ARRAY_SIZE accepted beats.
REQ-032 Unselected banks' raddr SHALL be held at 0.
REQ-033 start while busy SHALL be ignored, and captured parameters SHALL be unaffected by later input changes.

Reset
REQ-034 srst=1 SHALL immediately force: state IDLE, out_valid=0, out_last=0, out_data=0, busy=0, done=0, all raddr=0, and all counters and buffers to 0.
REQ-035 srst asserted mid-transfer SHALL abort the transfer with no further beats; after release, the block SHALL accept a new start.

Verification
REQ-036 Bank b, num_words=2, out_ready=1, words 0x0001..0008 and 0x0011..0018 -> 16 beats 0x0008..0x0001 then 0x0018..0x0011; out_last on beat 16; done one cycle later.
REQ-037 Same as REQ-036 but out_ready toggles 1,0,0,1 -> identical beat sequence, and out_data stable during stalls.
REQ-038 num_words=0 or bank_sel=3 -> no raddr change, no out_valid, done pulse in the cycle after start.
REQ-039 num_words=100, bank c -> exactly 512 beats, addresses 0..63, out_last on beat 512.
REQ-040 srst at beat 5 of word 0 -> all outputs 0 at once; a new start afterwards yields a full correct transfer.
REQ-041 start pulsed while busy with bank_sel=0 -> ignored; the transfer completes on the originally selected bank.
